// File: rtl/fp_add_if.sv
// Operand/result bundle for the single-cycle floating-point adder.
// master drives the two operands and samples the registered sum; slave is the adder.
interface fp_add_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
);
  localparam int W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;

  logic [W-1:0]              A_FP;
  logic [W-1:0]              B_FP;
  logic                      sign;
  logic [EXPONENT_WIDTH-1:0] exponent;
  logic [MANTISSA_WIDTH-1:0] mantissa;

  modport master (
    output A_FP, B_FP,
    input  sign, exponent, mantissa
  );

  modport slave (
    input  A_FP, B_FP,
    output sign, exponent, mantissa
  );
endinterface

// File: rtl/fp_add.sv
// IEEE-754-style adder, round-to-nearest-even, denormals flushed to zero.
// One-cycle latency, new operands every cycle, no backpressure.
module fp_add #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic   clk,
  input  logic   rst_n,
  fp_add_if.slave bus
);
  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int SW = MW + 4;   // hidden bit + fraction + guard/round/sticky
  localparam int XW = EW + 2;   // signed working exponent with headroom
  localparam logic [EW-1:0] EXP_MAX = '1;
  localparam logic [MW-1:0] QNAN_FRAC = {1'b1, {(MW-1){1'b0}}};

  // operand fields
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic          a_larger;

  // larger/smaller magnitude operands
  logic          sl;
  logic [EW-1:0] el, es;
  logic [MW-1:0] fl, fs;
  logic [EW-1:0] shift_amt;

  // datapath
  logic [SW-1:0] sig_l, ext_s, sig_s;
  logic          lost;
  logic [SW:0]   sum;
  logic [SW-1:0] norm;
  logic [XW-1:0] lzc;
  logic          found;
  logic signed [XW-1:0] exp_n, exp_r;
  logic          round_up;
  logic [MW+1:0] rnd;
  logic [MW-1:0] frac_r;

  // combinational result
  logic          res_sign;
  logic [EW-1:0] res_exp;
  logic [MW-1:0] res_frac;

  // registered result
  logic          sign_q;
  logic [EW-1:0] exp_q;
  logic [MW-1:0] frac_q;

  always_comb begin
    {sa, ea, fa} = bus.A_FP;
    {sb, eb, fb} = bus.B_FP;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_MAX) && (fa == '0);
    b_inf  = (eb == EXP_MAX) && (fb == '0);
    a_nan  = (ea == EXP_MAX) && (fa != '0);
    b_nan  = (eb == EXP_MAX) && (fb != '0);
    // Strict compare keeps the choice symmetric: ties only matter when the
    // magnitudes are identical, where either ordering gives the same answer.
    a_larger = {ea, fa} > {eb, fb};
  end

  always_comb begin
    if (a_larger) begin
      sl = sa; el = ea; fl = fa; es = eb; fs = fb;
    end else begin
      sl = sb; el = eb; fl = fb; es = ea; fs = fa;
    end
    shift_amt = el - es;
  end

  // Alignment of the smaller operand, collapsing shifted-out bits into sticky.
  always_comb begin
    sig_l = {1'b1, fl, 3'b000};
    ext_s = {1'b1, fs, 3'b000};
    sig_s = '0;
    lost  = 1'b0;
    if (int'(shift_amt) >= MW + 3) begin
      sig_s = {{(SW-1){1'b0}}, 1'b1};
    end else begin
      sig_s = ext_s >> shift_amt;
      for (int i = 0; i < SW; i++) begin
        if (i < int'(shift_amt)) lost = lost | ext_s[i];
      end
      sig_s[0] = sig_s[0] | lost;
    end
  end

  always_comb begin
    if (sa == sb) sum = {1'b0, sig_l} + {1'b0, sig_s};
    else          sum = {1'b0, sig_l} - {1'b0, sig_s};
  end

  // Normalization: carry shifts right (sticky preserved), otherwise left by lzc.
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lzc   = lzc + 1'b1;
      end
    end

    exp_n = $signed({2'b00, el});
    norm  = '0;
    if (sum[SW]) begin
      norm    = sum[SW:1];
      norm[0] = sum[1] | sum[0];
      exp_n   = exp_n + $signed(XW'(1));
    end else begin
      norm  = sum[SW-1:0] << lzc;
      exp_n = exp_n - $signed(lzc);
    end
  end

  // Round to nearest, ties to even; a carry out of the fraction renormalizes.
  always_comb begin
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[SW-1:3]} + {{(MW+1){1'b0}}, round_up};
    exp_r    = exp_n;
    frac_r   = rnd[MW-1:0];
    if (rnd[MW+1]) begin
      exp_r  = exp_n + $signed(XW'(1));
      frac_r = rnd[MW:1];
    end
  end

  // Special-case priority: NaN, infinity, zero operands, then the arithmetic path.
  always_comb begin
    res_sign = 1'b0;
    res_exp  = '0;
    res_frac = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      res_exp  = EXP_MAX;
      res_frac = QNAN_FRAC;
    end else if (a_inf) begin
      res_sign = sa;
      res_exp  = EXP_MAX;
    end else if (b_inf) begin
      res_sign = sb;
      res_exp  = EXP_MAX;
    end else if (a_zero && b_zero) begin
      res_sign = sa & sb;
    end else if (a_zero) begin
      {res_sign, res_exp, res_frac} = bus.B_FP;
    end else if (b_zero) begin
      {res_sign, res_exp, res_frac} = bus.A_FP;
    end else if (sum == '0) begin
      res_sign = 1'b0;
    end else if (exp_n[XW-1] || (exp_n == '0)) begin
      res_sign = sl;
    end else if (!exp_r[XW-1] && (exp_r >= $signed({2'b00, EXP_MAX}))) begin
      res_sign = sl;
      res_exp  = EXP_MAX;
    end else begin
      res_sign = sl;
      res_exp  = exp_r[EW-1:0];
      res_frac = frac_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      frac_q <= '0;
    end else begin
      sign_q <= res_sign;
      exp_q  <= res_exp;
      frac_q <= res_frac;
    end
  end

  assign bus.sign     = sign_q;
  assign bus.exponent = exp_q;
  assign bus.mantissa = frac_q;
endmodule

// File: tb/tb_fp_add.sv
// Directed-vector bench for fp_add: reset, arithmetic, specials, streaming, mid-stream reset.
module tb_fp_add;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fp_add_if bus ();

  fp_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observed();
    return {bus.sign, bus.exponent, bus.mantissa};
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_v);
    logic [31:0] got;
    got = observed();
    checks++;
    assert (got === exp_v)
    else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp_v);
    end
  endtask

  // Drive a pair just after an edge, then check one edge later.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_v);
    bus.A_FP = a;
    bus.B_FP = b;
    @(posedge clk);
    #1;
    check(tag, exp_v);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    bus.A_FP = 32'h40E80000;
    bus.B_FP = 32'h3EC00000;
    #3;
    check("reset_async", 32'h00000000);
    @(posedge clk);
    #1;
    check("reset_held_edge", 32'h00000000);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", 32'h40F40000);

    apply("add_6_7",        32'h40C00000, 32'h40E00000, 32'h41500000);
    apply("add_m7_m3",      32'hC0E00000, 32'hC0400000, 32'hC1200000);
    apply("sub_65_63",      32'h42820000, 32'hC27C0000, 32'h40000000);
    apply("sub_2p5_4p5",    32'h40200000, 32'hC0900000, 32'hC0000000);
    apply("cancel_4",       32'h40800000, 32'hC0800000, 32'h00000000);
    apply("cancel_half",    32'hBF000000, 32'h3F000000, 32'h00000000);
    apply("zero_plus_12",   32'h00000000, 32'h41400000, 32'h41400000);
    apply("negzero_plus_x", 32'h80000000, 32'hC0400000, 32'hC0400000);
    apply("negzero_sum",    32'h80000000, 32'h80000000, 32'h80000000);
    apply("inf_minus_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000);
    apply("nan_operand",    32'h7F800001, 32'h3F800000, 32'h7FC00000);
    apply("ninf_plus_one",  32'hFF800000, 32'h3F800000, 32'hFF800000);
    apply("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    apply("commute",        32'h3EC00000, 32'h40E80000, 32'h40F40000);
    apply("tie_even",       32'h3F800000, 32'h33800000, 32'h3F800000);
    apply("round_up",       32'h3F800000, 32'h34400000, 32'h3F800002);
    apply("underflow",      32'h00800000, 32'h80C00000, 32'h80000000);
    apply("far_shift",      32'h3F800000, 32'h00800000, 32'h3F800000);

    // Streaming: the output must still hold the prior result until the next edge.
    bus.A_FP = 32'h40C00000;
    bus.B_FP = 32'h40E00000;
    #1;
    check("hold_until_edge", 32'h3F800000);
    @(posedge clk);
    #1;
    check("stream_0", 32'h41500000);
    apply("stream_1", 32'h40200000, 32'hC0900000, 32'hC0000000);
    apply("stream_2", 32'h42820000, 32'hC27C0000, 32'h40000000);

    // Reset pulsed between edges, released before the next edge.
    bus.A_FP = 32'hC0E00000;
    bus.B_FP = 32'hC0400000;
    #1;
    rst_n = 1'b0;
    #1;
    check("midstream_reset", 32'h00000000);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_after_reset", 32'hC1200000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
